mem_req_arbiter: RTL and testbench

Shares the single DDR2 controller request path (address/command FIFO, write-data FIFO, read-data FIFO) between the instruction cache and the data cache inside Memory150. It accepts one line request at a time from either cache and sequences write lines as two 128-bit beats. It tracks the owner of every outstanding read so that returning read beats are steered to the cache that issued the read. Both caches connect only to this block; only this block drives the controller FIFOs.

---
 rtl/mem_req_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// Shares the DDR2 controller request path between icache and dcache.
// Line writes go out as two data beats followed by the address command.
module mem_req_arbiter #(
    parameter int ADDR_W          = 31,
    parameter int DATA_W          = 128,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  cpu_clk_g,
    input  logic                  rst_n,
    input  logic                  ic_req_valid,
    output logic                  ic_req_ready,
    input  logic                  ic_req_write,
    input  logic [ADDR_W-1:0]     ic_req_addr,
    input  logic [2*DATA_W-1:0]   ic_req_wdata,
    input  logic [2*DATA_W/8-1:0] ic_req_wmask,
    input  logic                  dc_req_valid,
    output logic                  dc_req_ready,
    input  logic                  dc_req_write,
    input  logic [ADDR_W-1:0]     dc_req_addr,
    input  logic [2*DATA_W-1:0]   dc_req_wdata,
    input  logic [2*DATA_W/8-1:0] dc_req_wmask,
    output logic                  ic_rdata_valid,
    output logic                  dc_rdata_valid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  af_wr_en,
    output logic [2:0]            af_cmd,
    output logic [ADDR_W-1:0]     af_addr_din,
    input  logic                  af_full,
    output logic                  wdf_wr_en,
    output logic [DATA_W-1:0]     wdf_din,
    output logic [DATA_W/8-1:0]   wdf_mask_din,
    input  logic                  wdf_full,
    input  logic                  rdf_valid,
    input  logic [DATA_W-1:0]     rdf_dout,
    output logic                  err_orphan
);

    localparam int MASK_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE,
        WD0,
        WD1,
        CMD
    } state_e;

    state_e state_q, state_d;
    logic grant_q, grant_d;
    logic last_grant_q, last_grant_d;
    logic [MAX_OUTSTANDING-1:0] own_q, own_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic beat_q, beat_d;
    logic err_q, err_d;

    logic q_full;
    logic q_empty;
    logic ic_elig;
    logic dc_elig;
    logic nxt_grant;
    logic push;
    logic pop;
    logic head;

    logic                  sel_write;
    logic [ADDR_W-1:0]     sel_addr;
    logic [2*DATA_W-1:0]   sel_wdata;
    logic [2*DATA_W/8-1:0] sel_wmask;

    assign q_full  = (cnt_q == FULL_CNT);
    assign q_empty = (cnt_q == '0);
    assign ic_elig = ic_req_valid && (ic_req_write || !q_full);
    assign dc_elig = dc_req_valid && (dc_req_write || !q_full);
    assign head    = own_q[rd_ptr_q];

    assign sel_write = grant_q ? dc_req_write : ic_req_write;
    assign sel_addr  = grant_q ? dc_req_addr  : ic_req_addr;
    assign sel_wdata = grant_q ? dc_req_wdata : ic_req_wdata;
    assign sel_wmask = grant_q ? dc_req_wmask : ic_req_wmask;

    assign rdata      = rdf_dout;
    assign err_orphan = err_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        nxt_grant    = 1'b0;
        push         = 1'b0;
        af_wr_en     = 1'b0;
        af_cmd       = 3'b000;
        af_addr_din  = '0;
        wdf_wr_en    = 1'b0;
        wdf_din      = '0;
        wdf_mask_din = '0;
        ic_req_ready = 1'b0;
        dc_req_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ic_elig || dc_elig) begin
                    // On a tie the side that did not win last time goes next.
                    nxt_grant    = (ic_elig && dc_elig) ? !last_grant_q : dc_elig;
                    grant_d      = nxt_grant;
                    last_grant_d = nxt_grant;
                    if (nxt_grant ? dc_req_write : ic_req_write) begin
                        state_d = WD0;
                    end else begin
                        state_d = CMD;
                    end
                end
            end
            WD0: begin
                wdf_wr_en    = !wdf_full;
                wdf_din      = sel_wdata[DATA_W-1:0];
                wdf_mask_din = sel_wmask[MASK_W-1:0];
                if (!wdf_full) begin
                    state_d = WD1;
                end
            end
            WD1: begin
                wdf_wr_en    = !wdf_full;
                wdf_din      = sel_wdata[2*DATA_W-1:DATA_W];
                wdf_mask_din = sel_wmask[2*MASK_W-1:MASK_W];
                if (!wdf_full) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                af_wr_en    = !af_full;
                af_cmd      = sel_write ? 3'b000 : 3'b001;
                af_addr_din = sel_addr;
                if (!af_full) begin
                    ic_req_ready = !grant_q;
                    dc_req_ready = grant_q;
                    push         = !sel_write;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pop            = 1'b0;
        beat_d         = beat_q;
        err_d          = err_q;
        ic_rdata_valid = 1'b0;
        dc_rdata_valid = 1'b0;
        if (rdf_valid) begin
            if (q_empty) begin
                err_d = 1'b1;
            end else begin
                ic_rdata_valid = !head;
                dc_rdata_valid = head;
                beat_d         = !beat_q;
                pop            = beat_q;
            end
        end
    end

    always_comb begin
        own_d    = own_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            own_d[wr_ptr_q] = grant_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge cpu_clk_g or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            own_q        <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            beat_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            own_q        <= own_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed scoreboard bench for mem_req_arbiter.
// Expected FIFO pushes and read routes are queued as stimulus is applied.
module tb_mem_req_arbiter;

    localparam int AW = 31;
    localparam int DW = 128;
    localparam int MW = DW / 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ic_req_valid, ic_req_ready, ic_req_write;
    logic [AW-1:0]   ic_req_addr;
    logic [2*DW-1:0] ic_req_wdata;
    logic [2*MW-1:0] ic_req_wmask;
    logic            dc_req_valid, dc_req_ready, dc_req_write;
    logic [AW-1:0]   dc_req_addr;
    logic [2*DW-1:0] dc_req_wdata;
    logic [2*MW-1:0] dc_req_wmask;
    logic            ic_rdata_valid, dc_rdata_valid;
    logic [DW-1:0]   rdata;
    logic            af_wr_en;
    logic [2:0]      af_cmd;
    logic [AW-1:0]   af_addr_din;
    logic            af_full;
    logic            wdf_wr_en;
    logic [DW-1:0]   wdf_din;
    logic [MW-1:0]   wdf_mask_din;
    logic            wdf_full;
    logic            rdf_valid;
    logic [DW-1:0]   rdf_dout;
    logic            err_orphan;

    always #5 clk = ~clk;

    mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(4)) dut (
        .cpu_clk_g(clk), .rst_n(rst_n),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
        .ic_req_write(ic_req_write), .ic_req_addr(ic_req_addr),
        .ic_req_wdata(ic_req_wdata), .ic_req_wmask(ic_req_wmask),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_write(dc_req_write), .dc_req_addr(dc_req_addr),
        .dc_req_wdata(dc_req_wdata), .dc_req_wmask(dc_req_wmask),
        .ic_rdata_valid(ic_rdata_valid), .dc_rdata_valid(dc_rdata_valid),
        .rdata(rdata),
        .af_wr_en(af_wr_en), .af_cmd(af_cmd), .af_addr_din(af_addr_din),
        .af_full(af_full),
        .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din),
        .wdf_full(wdf_full),
        .rdf_valid(rdf_valid), .rdf_dout(rdf_dout),
        .err_orphan(err_orphan)
    );

    typedef struct packed {
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        logic          dc;
    } af_t;
    typedef struct packed {
        logic [DW-1:0] d;
        logic [MW-1:0] m;
    } wd_t;
    typedef struct packed {
        logic          dc;
        logic [DW-1:0] d;
    } rd_t;

    af_t af_q[$];
    wd_t wd_q[$];
    rd_t rd_q[$];
    af_t ea;
    wd_t ew;
    rd_t er;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every push and every returned beat must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (af_wr_en) begin
                if (af_q.size() == 0) begin
                    chk("af_unexpected", 256'(1), 256'(0));
                end else begin
                    ea = af_q.pop_front();
                    chk("af_cmd", 256'(af_cmd), 256'(ea.cmd));
                    chk("af_addr", 256'(af_addr_din), 256'(ea.addr));
                    chk("ic_ready", 256'(ic_req_ready), 256'(!ea.dc));
                    chk("dc_ready", 256'(dc_req_ready), 256'(ea.dc));
                    if (ea.cmd == 3'b000) begin
                        chk("wdata_before_cmd", 256'(wd_q.size()), 256'(0));
                    end
                end
            end else if (ic_req_ready || dc_req_ready) begin
                chk("ready_without_af", 256'({ic_req_ready, dc_req_ready}), 256'(0));
            end
            if (wdf_wr_en) begin
                if (wd_q.size() == 0) begin
                    chk("wdf_unexpected", 256'(1), 256'(0));
                end else begin
                    ew = wd_q.pop_front();
                    chk("wdf_din", 256'(wdf_din), 256'(ew.d));
                    chk("wdf_mask", 256'(wdf_mask_din), 256'(ew.m));
                end
            end
            if (ic_rdata_valid || dc_rdata_valid) begin
                if (rd_q.size() == 0) begin
                    chk("rdata_unexpected", 256'(1), 256'(0));
                end else begin
                    er = rd_q.pop_front();
                    chk("rd_route", 256'({ic_rdata_valid, dc_rdata_valid}),
                        256'({!er.dc, er.dc}));
                    chk("rdata", 256'(rdata), 256'(er.d));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rdf_valid = 1'b0;
    endtask

    task automatic rd_req(input bit dc, input logic [AW-1:0] a);
        if (dc) begin
            dc_req_valid = 1'b1; dc_req_write = 1'b0; dc_req_addr = a;
        end else begin
            ic_req_valid = 1'b1; ic_req_write = 1'b0; ic_req_addr = a;
        end
        af_q.push_back('{3'b001, a, dc});
    endtask

    task automatic wr_req(input bit dc, input logic [AW-1:0] a,
                          input logic [2*DW-1:0] d, input logic [2*MW-1:0] m);
        if (dc) begin
            dc_req_valid = 1'b1; dc_req_write = 1'b1; dc_req_addr = a;
            dc_req_wdata = d; dc_req_wmask = m;
        end else begin
            ic_req_valid = 1'b1; ic_req_write = 1'b1; ic_req_addr = a;
            ic_req_wdata = d; ic_req_wmask = m;
        end
        wd_q.push_back('{d[DW-1:0], m[MW-1:0]});
        wd_q.push_back('{d[2*DW-1:DW], m[2*MW-1:MW]});
        af_q.push_back('{3'b000, a, dc});
    endtask

    task automatic wait_ready(input bit dc, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = dc ? dc_req_ready : ic_req_ready;
        end
        tick();
        if (dc) dc_req_valid = 1'b0;
        else ic_req_valid = 1'b0;
    endtask

    task automatic beat(input bit dc, input logic [DW-1:0] d);
        rdf_valid = 1'b1;
        rdf_dout  = d;
        rd_q.push_back('{dc, d});
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    int lat;

    initial begin
        ic_req_valid = 0; ic_req_write = 0; ic_req_addr = '0;
        ic_req_wdata = '0; ic_req_wmask = '0;
        dc_req_valid = 0; dc_req_write = 0; dc_req_addr = '0;
        dc_req_wdata = '0; dc_req_wmask = '0;
        af_full = 0; wdf_full = 0; rdf_valid = 0; rdf_dout = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_af_wr_en", 256'(af_wr_en), 256'(0));
        chk("rst_wdf_wr_en", 256'(wdf_wr_en), 256'(0));
        chk("rst_ready", 256'({ic_req_ready, dc_req_ready}), 256'(0));
        chk("rst_rvalid", 256'({ic_rdata_valid, dc_rdata_valid}), 256'(0));
        chk("rst_af_bus", 256'({af_cmd, af_addr_din}), 256'(0));
        chk("rst_wdf_bus", 256'({wdf_din, wdf_mask_din}), 256'(0));
        chk("rst_err", 256'(err_orphan), 256'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // single dcache read and its two-beat return
        rd_req(1'b1, 31'h0000100);
        wait_ready(1'b1, lat);
        chk("rd_latency", 256'(lat), 256'(2));
        beat(1'b1, {16{8'hAA}});
        beat(1'b1, {16{8'hBB}});
        chk("rd1_drained", 256'(rd_q.size()), 256'(0));

        // dcache write: beat 0, beat 1, then command
        wr_req(1'b1, 31'h0040000, {{16{8'hB1}}, {16{8'hB0}}}, '0);
        wait_ready(1'b1, lat);
        chk("wr_latency", 256'(lat), 256'(4));
        chk("wr_wdf_done", 256'(wd_q.size()), 256'(0));

        // simultaneous reads after reset: dcache first
        do_reset();
        rd_req(1'b1, 31'h0000D00);
        rd_req(1'b0, 31'h0000C00);
        wait_ready(1'b1, lat);
        chk("tie_dc_latency", 256'(lat), 256'(2));
        wait_ready(1'b0, lat);
        chk("tie_ic_latency", 256'(lat), 256'(2));
        beat(1'b1, {16{8'hD0}});
        beat(1'b1, {16{8'hD1}});
        beat(1'b0, {16{8'hC0}});
        beat(1'b0, {16{8'hC1}});

        // fill the owner queue; a fifth read must wait, a write must not
        for (int i = 0; i < 4; i++) begin
            rd_req(1'b0, AW'(32'h200 + i));
            wait_ready(1'b0, lat);
            chk("fill_latency", 256'(lat), 256'(2));
        end
        wr_req(1'b1, 31'h0000400, {{16{8'h44}}, {16{8'h33}}}, 32'h00F0_0F00);
        rd_req(1'b0, 31'h0000300);
        wait_ready(1'b1, lat);
        chk("full_wr_latency", 256'(lat), 256'(4));
        repeat (3) begin
            @(negedge clk);
            chk("full_rd_held", 256'(ic_req_ready), 256'(0));
            tick();
        end
        beat(1'b0, {16{8'h10}});
        beat(1'b0, {16{8'h11}});
        wait_ready(1'b0, lat);
        chk("unblock_latency", 256'(lat), 256'(2));
        for (int i = 0; i < 8; i++) begin
            beat(1'b0, DW'(32'h5000 + i));
        end

        // backpressure: wdf_full 2 cycles in WD1, af_full 3 cycles in CMD
        wr_req(1'b0, 31'h0000500, {{16{8'h66}}, {16{8'h55}}}, 32'h0000_F00F);
        tick();
        @(negedge clk);
        chk("bp_wd0_push", 256'(wdf_wr_en), 256'(1));
        tick();
        wdf_full = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("bp_wdf_nopush", 256'(wdf_wr_en), 256'(0));
            chk("bp_wdf_hold", 256'(wdf_din), 256'({16{8'h66}}));
            chk("bp_wdf_noready", 256'(ic_req_ready), 256'(0));
            tick();
        end
        wdf_full = 1'b0;
        @(negedge clk);
        chk("bp_wd1_push", 256'(wdf_wr_en), 256'(1));
        tick();
        af_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_af_nopush", 256'(af_wr_en), 256'(0));
            chk("bp_af_noready", 256'(ic_req_ready), 256'(0));
            chk("bp_af_addr", 256'(af_addr_din), 256'(31'h0000500));
            tick();
        end
        af_full = 1'b0;
        wait_ready(1'b0, lat);
        chk("bp_ready_latency", 256'(lat), 256'(1));

        // orphan beat
        @(negedge clk);
        chk("no_orphan_yet", 256'(err_orphan), 256'(0));
        tick();
        rdf_valid = 1'b1;
        rdf_dout  = {16{8'hEE}};
        @(negedge clk);
        chk("orphan_no_rvalid", 256'({ic_rdata_valid, dc_rdata_valid}), 256'(0));
        tick();
        repeat (2) tick();
        @(negedge clk);
        chk("orphan_sticky", 256'(err_orphan), 256'(1));
        tick();

        // async reset in the middle of a write, in WD1
        wr_req(1'b1, 31'h0000600, {{16{8'h88}}, {16{8'h77}}}, '0);
        tick();
        tick();
        chk("mid_beat0_pushed", 256'(wd_q.size()), 256'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wdf", 256'({wdf_wr_en, wdf_din, wdf_mask_din}), 256'(0));
        chk("mid_rst_af", 256'({af_wr_en, af_cmd, af_addr_din}), 256'(0));
        chk("mid_rst_ready", 256'({ic_req_ready, dc_req_ready}), 256'(0));
        chk("mid_rst_err", 256'(err_orphan), 256'(0));
        dc_req_valid = 1'b0;
        wd_q.delete();
        af_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_idle", 256'({af_wr_en, wdf_wr_en}), 256'(0));
        tick();
        rd_req(1'b0, 31'h0000700);
        wait_ready(1'b0, lat);
        chk("post_rst_rd", 256'(lat), 256'(2));
        beat(1'b0, {16{8'h70}});
        beat(1'b0, {16{8'h71}});
        tick();

        chk("end_af_q", 256'(af_q.size()), 256'(0));
        chk("end_wd_q", 256'(wd_q.size()), 256'(0));
        chk("end_rd_q", 256'(rd_q.size()), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
